// File: rtl/swerv_trace_buf.sv
// Retire-trace capture FIFO: compacts up to NLANES valid lanes per cycle into single-instruction entries.
// Push visible on out_valid one cycle later (FWFT head); packets that do not fit whole are dropped and counted.
module swerv_trace_buf #(
  parameter int NLANES = 3,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       trace_en,
  input  logic                       clr,
  input  logic [NLANES-1:0]          in_valid,
  input  logic [NLANES*32-1:0]       in_insn,
  input  logic [NLANES*32-1:0]       in_addr,
  input  logic [NLANES-1:0]          in_exception,
  input  logic [NLANES-1:0]          in_interrupt,
  input  logic [4:0]                 in_ecause,
  input  logic [31:0]                in_tval,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [31:0]                out_addr,
  output logic                       out_exc,
  output logic                       out_int,
  output logic [4:0]                 out_ecause,
  output logic [31:0]                out_tval,
  output logic [1:0]                 out_lane,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        irq;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [1:0]  lane;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_overflow;

  entry_t            w_ent  [NLANES];
  logic [AW-1:0]     w_slot [NLANES];
  logic [LW-1:0]     w_cnt;
  logic [LW-1:0]     w_n;
  logic [LW-1:0]     w_space;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  entry_t            w_head;

  // w_slot[i] is the number of valid lanes below i, i.e. the lane's offset from wr_ptr.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NLANES; i++) begin
      w_slot[i]        = w_cnt[AW-1:0];
      w_ent[i].insn    = in_insn[32*i +: 32];
      w_ent[i].addr    = in_addr[32*i +: 32];
      w_ent[i].exc     = in_exception[i];
      w_ent[i].irq     = in_interrupt[i];
      w_ent[i].ecause  = (in_exception[i] | in_interrupt[i]) ? in_ecause : 5'd0;
      w_ent[i].tval    = (in_exception[i] | in_interrupt[i]) ? in_tval : 32'd0;
      w_ent[i].lane    = 2'(i);
      if (in_valid[i]) w_cnt = w_cnt + LW'(1);
    end
  end

  assign w_n     = trace_en ? w_cnt : '0;
  assign w_space = LW'(DEPTH) - r_level;
  assign w_drop  = (w_n > w_space);
  assign w_push  = trace_en && !w_drop;
  assign w_pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst_l && !clr && w_push) begin
      for (int i = 0; i < NLANES; i++) begin
        if (in_valid[i]) r_mem[r_wr_ptr + w_slot[i]] <= w_ent[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l || clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A packet of exactly DEPTH lanes truncates to 0 here, which is the correct wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + w_n[AW-1:0];
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (w_push ? w_n : LW'(0)) - LW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  assign out_valid  = (r_level != '0);
  assign w_head     = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_insn   = w_head.insn;
  assign out_addr   = w_head.addr;
  assign out_exc    = w_head.exc;
  assign out_int    = w_head.irq;
  assign out_ecause = w_head.ecause;
  assign out_tval   = w_head.tval;
  assign out_lane   = w_head.lane;
  assign level      = r_level;
  assign drop_cnt   = r_drop_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_swerv_trace_buf.sv
// Bench for swerv_trace_buf: directed scenarios plus random traffic against a queue-based packet model.
module tb_swerv_trace_buf;
  localparam int NL = 3;
  localparam int DP = 16;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              rst_l, trace_en, clr, out_ready;
  logic [NL-1:0]     in_valid, in_exception, in_interrupt;
  logic [NL*32-1:0]  in_insn, in_addr;
  logic [4:0]        in_ecause;
  logic [31:0]       in_tval;
  logic              out_valid, out_exc, out_int, overflow;
  logic [31:0]       out_insn, out_addr, out_tval;
  logic [4:0]        out_ecause;
  logic [1:0]        out_lane;
  logic [4:0]        level;
  logic [DW-1:0]     drop_cnt;

  swerv_trace_buf #(.NLANES(NL), .DEPTH(DP), .DROP_W(DW)) dut (
    .clk(clk), .rst_l(rst_l), .trace_en(trace_en), .clr(clr),
    .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr),
    .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_ecause(in_ecause), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_int(out_int),
    .out_ecause(out_ecause), .out_tval(out_tval), .out_lane(out_lane),
    .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        irq;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [1:0]  lane;
  } ent_t;

  ent_t q[$];
  int   m_drop;
  bit   m_ovf;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input ent_t e);
    return {23'd0, e.insn, e.addr, e.exc, e.irq, e.ecause, e.tval, e.lane};
  endfunction

  // Advance one clock: update the packet model from the inputs sampled at the edge, then compare.
  task automatic tick();
    int   n;
    int   space;
    bit   pop;
    ent_t e;
    @(posedge clk);
    if (!rst_l || clr) begin
      q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      n     = trace_en ? $countones(in_valid) : 0;
      space = DP - q.size();
      pop   = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (n > space) begin
        m_ovf = 1'b1;
        if (m_drop < (1 << DW) - 1) m_drop++;
      end else if (n > 0) begin
        for (int i = 0; i < NL; i++) begin
          if (in_valid[i]) begin
            e.insn   = in_insn[32*i +: 32];
            e.addr   = in_addr[32*i +: 32];
            e.exc    = in_exception[i];
            e.irq    = in_interrupt[i];
            e.ecause = (e.exc | e.irq) ? in_ecause : 5'd0;
            e.tval   = (e.exc | e.irq) ? in_tval : 32'd0;
            e.lane   = 2'(i);
            q.push_back(e);
          end
        end
      end
    end
    #1;
    check("valid", 128'(out_valid), 128'(q.size() != 0));
    check("level", 128'(level), 128'(q.size()));
    check("head", {23'd0, out_insn, out_addr, out_exc, out_int, out_ecause, out_tval, out_lane},
          (q.size() != 0) ? pack(q[0]) : 128'd0);
    check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    check("overflow", 128'(overflow), 128'(m_ovf));
  endtask

  task automatic drive(input logic [NL-1:0] v);
    in_valid = v;
    for (int i = 0; i < NL; i++) begin
      in_insn[32*i +: 32] = $urandom();
      in_addr[32*i +: 32] = $urandom();
      in_exception[i]     = ($urandom_range(0, 3) == 0);
      in_interrupt[i]     = ($urandom_range(0, 5) == 0);
    end
    in_ecause = 5'($urandom());
    in_tval   = $urandom();
  endtask

  initial begin
    checks = 0; errors = 0; m_drop = 0; m_ovf = 1'b0;
    rst_l = 1'b0; trace_en = 1'b1; clr = 1'b0; out_ready = 1'b1;
    drive('0);
    tick();
    tick();
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_insn", 128'(out_insn), 128'd0);
    rst_l = 1'b1;

    // Two lanes with a hole between them compact into consecutive entries.
    drive(3'b101);
    in_insn[31:0]  = 32'h13;
    in_insn[95:64] = 32'h33;
    tick();
    check("t1_lvl2", 128'(level), 128'd2);
    check("t1_insn0", 128'(out_insn), 128'h13);
    check("t1_lane0", 128'(out_lane), 128'd0);
    drive('0);
    tick();
    check("t1_lvl1", 128'(level), 128'd1);
    check("t1_insn1", 128'(out_insn), 128'h33);
    check("t1_lane2", 128'(out_lane), 128'd2);
    tick();
    check("t1_lvl0", 128'(level), 128'd0);

    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(3'b111);
      tick();
    end
    check("t2_lvl15", 128'(level), 128'd15);
    drive(3'b011);
    tick();
    check("t2_drop", 128'(drop_cnt), 128'd1);
    check("t2_ovf", 128'(overflow), 128'd1);
    check("t2_lvl", 128'(level), 128'd15);

    out_ready = 1'b1;
    drive(3'b001);
    tick();
    check("t3_pushpop", 128'(level), 128'd15);
    out_ready = 1'b0;
    drive(3'b100);
    tick();
    check("t3_full", 128'(level), 128'd16);
    out_ready = 1'b1;
    drive(3'b010);
    tick();
    check("t3_fulldrop", 128'(drop_cnt), 128'd2);
    check("t3_lvl", 128'(level), 128'd15);

    clr = 1'b1;
    drive(3'b111);
    tick();
    clr = 1'b0;
    check("clr_lvl", 128'(level), 128'd0);
    check("clr_drop", 128'(drop_cnt), 128'd0);

    out_ready = 1'b0;
    drive(3'b011);
    in_exception = 3'b010;
    in_interrupt = 3'b000;
    in_ecause = 5'd2;
    in_tval = 32'hDEAD;
    tick();
    check("t4_ec0", 128'(out_ecause), 128'd0);
    check("t4_tv0", 128'(out_tval), 128'd0);
    out_ready = 1'b1;
    drive('0);
    tick();
    check("t4_ec1", 128'(out_ecause), 128'd2);
    check("t4_tv1", 128'(out_tval), 128'hDEAD);
    check("t4_lane1", 128'(out_lane), 128'd1);
    tick();

    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) begin
      drive(3'b111);
      tick();
    end
    check("t5_sat", 128'(drop_cnt), 128'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_drop", 128'(drop_cnt), 128'd0);
    check("t5_clr_ovf", 128'(overflow), 128'd0);
    check("t5_clr_vld", 128'(out_valid), 128'd0);

    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
        drive(NL'(1 << $urandom_range(0, NL - 1)));
        tick();
      end
      out_ready = 1'b1;
      drive('0);
      for (int k = 0; k < 10; k++) tick();
      check("t6_empty", 128'(level), 128'd0);
    end
    out_ready = 1'b0;
    drive(3'b111);
    tick();
    rst_l = 1'b0;
    drive(3'b111);
    tick();
    rst_l = 1'b1;
    check("t6_rst_lvl", 128'(level), 128'd0);
    check("t6_rst_vld", 128'(out_valid), 128'd0);

    for (int k = 0; k < 3000; k++) begin
      drive(NL'($urandom()));
      trace_en  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 199) == 0);
      rst_l     = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
